// File: rtl/req_encoder_pkg.sv
// Shared definitions for the request encoder: default sizes, controller state
// encoding and the log2 helper used to cross-check the code width.
package req_encoder_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = 2;

  // Controller states: IDLE has no code on offer, HOLD presents code_out.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } enc_state_e;

  // Ceiling log2, used at elaboration to check W against N.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/req_encoder_prio_pick.sv
// Combinational priority picker: returns the index of the highest set bit of
// in_vec plus a flag that says whether any bit is set at all.
module prio_pick
  import req_encoder_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic [N-1:0] in_vec,
  output logic [W-1:0] idx,
  output logic         any
);

  // Ascending scan so that the last (highest) set bit wins.
  always_comb begin
    idx = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (in_vec[i]) begin
        idx = W'(i);
      end else begin
        idx = idx;
      end
    end
    any = |in_vec;
  end

endmodule

// File: rtl/req_encoder.sv
// req_encoder: clocked N-to-log2(N) priority encoder with a valid/ready output.
// Request bits are collected into a pending set; one code is offered at a time,
// highest index first, and held stable until the consumer takes it.
// Optional feature macro: ENC_OVERRUN_EN adds a sticky flag that records a
// request arriving for a bit that is already pending (a merged, lost event).
module req_encoder
  import req_encoder_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d_in,
  output logic [W-1:0] code_out,
  output logic         valid_out,
  input  logic         ready_in,
  output logic [N-1:0] pend_out,
  output logic         ovr_out
);

  // Elaboration-time guard: the code width must be exactly log2(N).
  if (W != clog2(N) || N < 2) begin : g_size_check
    $error("req_encoder: W must equal log2(N) and N must be >= 2");
  end

  enc_state_e     st_r;
  enc_state_e     st_nxt_s;
  logic [W-1:0]   code_r;
  logic [W-1:0]   code_nxt_s;
  logic [N-1:0]   pend_r;
  logic [N-1:0]   pend_nxt_s;
  logic           xfer_s;
  logic [N-1:0]   clr_s;
  logic [N-1:0]   cand_s;
  logic [W-1:0]   pick_s;
  logic           any_s;

  prio_pick #(
    .N (N),
    .W (W)
  ) u_pick (
    .in_vec (cand_s),
    .idx    (pick_s),
    .any    (any_s)
  );

  // Candidate set: the offered bit is cleared on a transfer before new
  // requests are merged, so a same-cycle request for it re-arms the bit.
  always_comb begin
    xfer_s = (st_r == ST_HOLD) & ready_in;
    clr_s  = {N{1'b0}};
    if (xfer_s) begin
      clr_s[code_r] = 1'b1;
    end else begin
      clr_s = {N{1'b0}};
    end
    cand_s = (pend_r & ~clr_s) | d_in;
  end

  // Next-state logic: load a code when leaving IDLE or after a transfer;
  // while waiting in HOLD the offered code is frozen and requests only merge.
  always_comb begin
    st_nxt_s   = st_r;
    code_nxt_s = code_r;
    pend_nxt_s = pend_r;
    case (st_r)
      ST_IDLE: begin
        pend_nxt_s = cand_s;
        if (any_s) begin
          st_nxt_s   = ST_HOLD;
          code_nxt_s = pick_s;
        end else begin
          st_nxt_s   = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (xfer_s) begin
          pend_nxt_s = cand_s;
          if (any_s) begin
            code_nxt_s = pick_s;
          end else begin
            st_nxt_s   = ST_IDLE;
          end
        end else begin
          pend_nxt_s = pend_r | d_in;
        end
      end
      default: begin
        st_nxt_s   = ST_IDLE;
        pend_nxt_s = {N{1'b0}};
      end
    endcase
  end

  // State, code and pending-set registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_r   <= ST_IDLE;
      code_r <= {W{1'b0}};
      pend_r <= {N{1'b0}};
    end else begin
      st_r   <= st_nxt_s;
      code_r <= code_nxt_s;
      pend_r <= pend_nxt_s;
    end
  end

  assign code_out  = code_r;
  assign valid_out = (st_r == ST_HOLD);
  assign pend_out  = pend_r;

`ifdef ENC_OVERRUN_EN
  logic ovr_r;

  // Sticky overrun: a request hits a bit still pending after this cycle's
  // clear, so two events collapse into one code. Only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_r <= 1'b0;
    end else if (|((pend_r & ~clr_s) & d_in)) begin
      ovr_r <= 1'b1;
    end else begin
      ovr_r <= ovr_r;
    end
  end

  assign ovr_out = ovr_r;
`else
  assign ovr_out = 1'b0;
`endif

endmodule

// File: tb/tb_req_encoder.sv
// Self-checking bench for req_encoder: directed scenarios followed by random
// traffic, all compared cycle by cycle against a set-based reference model.
module tb_req_encoder;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk;
  logic         rst;
  logic [N-1:0] d_in;
  logic [W-1:0] code_out;
  logic         valid_out;
  logic         ready_in;
  logic [N-1:0] pend_out;
  logic         ovr_out;

  int checks;
  int failures;
  int zero_emits;

  // Reference model state
  bit [N-1:0] m_pend;
  int         m_code;
  bit         m_valid;
  bit         m_ovr;

  req_encoder #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .d_in      (d_in),
    .code_out  (code_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .pend_out  (pend_out),
    .ovr_out   (ovr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int highest(input bit [N-1:0] s);
    int h;
    h = -1;
    for (int k = 0; k < N; k++) begin
      if (s[k]) h = k;
    end
    return h;
  endfunction

  // One clock of the reference behaviour, derived from the set rules.
  task automatic model_step(input bit [N-1:0] d, input bit r, input bit rs);
    bit [N-1:0] keep;
    bit         xfer;
    if (rs) begin
      m_pend = '0; m_valid = 1'b0; m_code = 0; m_ovr = 1'b0;
    end else begin
      xfer = m_valid && r;
      keep = m_pend;
      if (xfer) keep[m_code] = 1'b0;
`ifdef ENC_OVERRUN_EN
      if ((keep & d) != '0) m_ovr = 1'b1;
`endif
      if (m_valid && !xfer) begin
        m_pend = m_pend | d;
      end else begin
        m_pend = keep | d;
        if (m_pend != '0) begin
          m_valid = 1'b1;
          m_code  = highest(m_pend);
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_model();
    chk("valid", int'(valid_out), int'(m_valid));
    chk("pend", int'(pend_out), int'(m_pend));
    chk("ovr", int'(ovr_out), int'(m_ovr));
    if (m_valid) chk("code", int'(code_out), m_code);
  endtask

  task automatic step(input bit [N-1:0] d, input bit r, input bit rs);
    d_in = d; ready_in = r; rst = rs;
    if (valid_out === 1'b1 && r && !rs && code_out === 2'd0) zero_emits++;
    @(posedge clk);
    model_step(d, r, rs);
    #1;
    check_model();
    @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0; zero_emits = 0;
    m_pend = '0; m_code = 0; m_valid = 1'b0; m_ovr = 1'b0;
    d_in = '0; ready_in = 1'b0; rst = 1'b1;
    @(negedge clk);

    // 1: reset two cycles with all requests high
    step(4'b1111, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b1);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_pend", int'(pend_out), 0);
    chk("rst_ovr", int'(ovr_out), 0);

    // 2: single request, consumer always ready
    step(4'b0100, 1'b1, 1'b0);
    chk("t2_code", int'(code_out), 2);
    chk("t2_valid", int'(valid_out), 1);
    step(4'b0000, 1'b1, 1'b0);
    chk("t2_idle", int'(valid_out), 0);
    chk("t2_pend", int'(pend_out), 0);

    // 3: three requests drained back to back, highest first
    step(4'b1011, 1'b1, 1'b0);
    chk("t3_c3", int'(code_out), 3);
    step(4'b0000, 1'b1, 1'b0);
    chk("t3_c1", int'(code_out), 1);
    step(4'b0000, 1'b1, 1'b0);
    chk("t3_c0", int'(code_out), 0);
    step(4'b0000, 1'b1, 1'b0);
    chk("t3_idle", int'(valid_out), 0);

    // 4: held code stays put while a higher request arrives
    step(4'b0010, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step((i == 2) ? 4'b1000 : 4'b0000, 1'b0, 1'b0);
      chk("t4_hold", int'(code_out), 1);
    end
    step(4'b0000, 1'b1, 1'b0);
    chk("t4_next", int'(code_out), 3);
    step(4'b0000, 1'b1, 1'b0);
    chk("t4_idle", int'(valid_out), 0);

    // 5: repeated request for a pending bit merges into one code
    step(4'b0000, 1'b0, 1'b1);
    zero_emits = 0;
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    chk("t5_one_code", zero_emits, 1);
`ifdef ENC_OVERRUN_EN
    chk("t5_ovr", int'(ovr_out), 1);
`else
    chk("t5_ovr", int'(ovr_out), 0);
`endif

    // 6: reset during HOLD drops everything
    step(4'b1100, 1'b0, 1'b0);
    chk("t6_hold", int'(pend_out), 12);
    step(4'b0000, 1'b1, 1'b1);
    chk("t6_valid", int'(valid_out), 0);
    chk("t6_pend", int'(pend_out), 0);
    step(4'b0000, 1'b0, 1'b0);
    chk("t6_quiet", int'(valid_out), 0);

    // Random traffic, including same-cycle re-arm and occasional reset
    for (int i = 0; i < 400; i++) begin
      bit [N-1:0] d;
      d = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      step(d, bit'($urandom_range(0, 1)), ($urandom_range(0, 60) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
